// File: rtl/bidir_io_bank_if.sv
// bidir_io_bank_if: fabric/pad-ring signal bundle for the bidirectional pad bank
interface bidir_io_bank_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] i_pad, o_pad, o_oe, i_dat, o_dat;
   logic dir_req, dir, busy, i_en, i_valid, o_valid, o_ready;
   modport master (output i_pad, dir_req, i_en, o_dat, o_valid,
                   input o_pad, o_oe, dir, busy, i_dat, i_valid, o_ready);
   modport slave (input i_pad, dir_req, i_en, o_dat, o_valid,
                  output o_pad, o_oe, dir, busy, i_dat, i_valid, o_ready);
endinterface

// File: rtl/bidir_io_bank.sv
// bidir_io_bank: registered bidirectional pad bank with dead-cycle direction turnaround
module bidir_io_bank #(
   parameter int WIDTH    = 8,
   parameter int IN_SYNC  = 2,
   parameter int TURN_CYC = 1
) (
   input logic clk,
   input logic rst,
   bidir_io_bank_if.slave io
);
   typedef enum logic [1:0] {RX, T2TX, TX, T2RX} state_t;
   localparam int SN = IN_SYNC == 0 ? 1 : IN_SYNC;
   localparam logic [3:0] TC_LAST = 4'(TURN_CYC == 0 ? 0 : TURN_CYC - 1);
   localparam logic [1:0] FC_MAX = 2'(IN_SYNC);
   state_t state_q, state_d;
   logic [3:0] tc_q, tc_d;
   logic [1:0] fc_q, fc_d;
   logic [WIDTH-1:0] out_q, out_d, sync_out;
   logic [WIDTH-1:0] sync_q [SN];
   logic [WIDTH-1:0] sync_d [SN];
   logic oe_q, oe_d, busy_q, busy_d;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX:   state_d = io.dir_req ? (TURN_CYC == 0 ? TX : T2TX) : RX;
         T2TX: state_d = tc_q == TC_LAST ? TX : T2TX;
         TX:   state_d = !io.dir_req ? (TURN_CYC == 0 ? RX : T2RX) : TX;
         T2RX: state_d = tc_q == TC_LAST ? RX : T2RX;
      endcase
      tc_d = (state_q == T2TX || state_q == T2RX) && state_d == state_q ? tc_q + 4'd1 : '0;
      fc_d = state_q != RX ? '0 : fc_q == FC_MAX ? fc_q : fc_q + 2'd1;
      // out reg is zero whenever the next state is not TX, so O_PAD falls with O_OE
      out_d = state_d != TX ? '0 : state_q == TX && io.o_valid ? io.o_dat : out_q;
      oe_d = state_d == TX;
      busy_d = state_d == T2TX || state_d == T2RX;
      sync_d[0] = io.i_pad;
      for (int i = 1; i < SN; i++) sync_d[i] = sync_q[i-1];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX;
         tc_q <= '0;
         fc_q <= '0;
         out_q <= '0;
         oe_q <= 1'b0;
         busy_q <= 1'b0;
         sync_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         tc_q <= tc_d;
         fc_q <= fc_d;
         out_q <= out_d;
         oe_q <= oe_d;
         busy_q <= busy_d;
         sync_q <= sync_d;
      end
   end
   assign sync_out = IN_SYNC == 0 ? io.i_pad : sync_q[SN-1];
   assign io.o_oe = {WIDTH{oe_q}};
   assign io.o_pad = out_q;
   assign io.dir = oe_q;
   assign io.o_ready = oe_q;
   assign io.busy = busy_q;
   assign io.i_valid = io.i_en && state_q == RX && fc_q == FC_MAX;
   assign io.i_dat = io.i_valid ? sync_out : '0;
endmodule

// File: tb/tb_bidir_io_bank.sv
// tb_bidir_io_bank: directed checks of reset, RX sync latency, turnaround and TX path
module tb_bidir_io_bank;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   logic [5:0] pb, po, pv;
   always #5 clk = ~clk;
   bidir_io_bank_if #(.WIDTH(8)) ia ();
   bidir_io_bank_if #(.WIDTH(8)) ib ();
   bidir_io_bank #(.WIDTH(8), .IN_SYNC(2), .TURN_CYC(3)) u_a (.clk(clk), .rst(rst), .io(ia));
   bidir_io_bank #(.WIDTH(8), .IN_SYNC(0), .TURN_CYC(2)) u_b (.clk(clk), .rst(rst), .io(ib));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1;
      ia.i_pad = 8'hFF; ia.dir_req = 1'b1; ia.i_en = 1'b1; ia.o_dat = 8'h00; ia.o_valid = 1'b0;
      ib.i_pad = 8'hFF; ib.dir_req = 1'b1; ib.i_en = 1'b0; ib.o_dat = 8'h00; ib.o_valid = 1'b0;
      repeat (2) begin
         nxt();
         chk("rst_oe", ia.o_oe, 8'h00);
         chk("rst_pad", ia.o_pad, 8'h00);
         chk("rst_idat", ia.i_dat, 8'h00);
         chk("rst_ivalid", ia.i_valid, 1'b0);
         chk("rst_b_oe", ib.o_oe, 8'h00);
      end
      rst = 1'b0; ia.dir_req = 1'b0; ib.dir_req = 1'b0;
      ia.i_pad = 8'hA5; ib.i_pad = 8'hC3; ib.i_en = 1'b1;
      nxt();
      chk("rel_dir", ia.dir, 1'b0);
      chk("rel_busy", ia.busy, 1'b0);
      chk("rel_ivalid", ia.i_valid, 1'b0);
      chk("b_comb_valid", ib.i_valid, 1'b1);
      chk("b_comb_dat", ib.i_dat, 8'hC3);
      nxt();
      chk("rx_valid", ia.i_valid, 1'b1);
      chk("rx_dat", ia.i_dat, 8'hA5);
      ia.i_en = 1'b0;
      nxt();
      chk("en0_dat", ia.i_dat, 8'h00);
      chk("en0_valid", ia.i_valid, 1'b0);
      ia.i_en = 1'b1; ia.i_pad = 8'h5A;
      nxt();
      chk("sync_old", ia.i_dat, 8'hA5);
      nxt();
      chk("sync_new", ia.i_dat, 8'h5A);
      ia.dir_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         nxt();
         chk("t2tx_busy", ia.busy, 1'b1);
         chk("t2tx_oe", ia.o_oe, 8'h00);
         chk("t2tx_ivalid", ia.i_valid, 1'b0);
         if (k == 1) begin ia.o_valid = 1'b1; ia.o_dat = 8'h77; end
      end
      nxt();
      chk("tx_oe", ia.o_oe, 8'hFF);
      chk("tx_pad0", ia.o_pad, 8'h00);
      chk("tx_ready", ia.o_ready, 1'b1);
      chk("tx_dir", ia.dir, 1'b1);
      chk("tx_busy", ia.busy, 1'b0);
      chk("tx_ivalid", ia.i_valid, 1'b0);
      ia.o_dat = 8'h3C;
      nxt();
      chk("tx_pad", ia.o_pad, 8'h3C);
      ia.o_valid = 1'b0; ia.o_dat = 8'hFF;
      nxt();
      chk("tx_hold", ia.o_pad, 8'h3C);
      ia.dir_req = 1'b0;
      nxt();
      chk("t2rx_oe", ia.o_oe, 8'h00);
      chk("t2rx_pad", ia.o_pad, 8'h00);
      chk("t2rx_ready", ia.o_ready, 1'b0);
      chk("t2rx_busy", ia.busy, 1'b1);
      repeat (2) begin
         nxt();
         chk("t2rx_busy", ia.busy, 1'b1);
      end
      nxt();
      chk("rx_back_busy", ia.busy, 1'b0);
      chk("rx_back_dir", ia.dir, 1'b0);
      chk("rx_back_v0", ia.i_valid, 1'b0);
      nxt();
      chk("rx_back_v1", ia.i_valid, 1'b0);
      nxt();
      chk("rx_back_v2", ia.i_valid, 1'b1);
      chk("rx_back_dat", ia.i_dat, 8'h5A);
      ib.dir_req = 1'b1;
      pb = 6'b011011; po = 6'b000100; pv = 6'b100000;
      for (int k = 0; k < 6; k++) begin
         nxt();
         chk("rev_busy", ib.busy, pb[k]);
         chk("rev_oe", ib.o_oe, {8{po[k]}});
         chk("rev_ivalid", ib.i_valid, pv[k]);
         chk("rev_overlap", ib.o_oe[0] & ib.i_valid, 1'b0);
         if (k == 0) ib.dir_req = 1'b0;
      end
      chk("rev_dat", ib.i_dat, 8'hC3);
      ia.dir_req = 1'b1; ia.o_valid = 1'b1; ia.o_dat = 8'h3C;
      repeat (4) nxt();
      chk("r6_oe", ia.o_oe, 8'hFF);
      nxt();
      chk("r6_pad", ia.o_pad, 8'h3C);
      rst = 1'b1; ia.o_valid = 1'b0;
      nxt();
      chk("r6_rst_oe", ia.o_oe, 8'h00);
      chk("r6_rst_pad", ia.o_pad, 8'h00);
      chk("r6_rst_dir", ia.dir, 1'b0);
      chk("r6_rst_busy", ia.busy, 1'b0);
      chk("r6_rst_ivalid", ia.i_valid, 1'b0);
      rst = 1'b0; ia.dir_req = 1'b0;
      nxt();
      chk("r6_fc1", ia.i_valid, 1'b0);
      nxt();
      chk("r6_fc2", ia.i_valid, 1'b1);
      chk("r6_dat", ia.i_dat, 8'h5A);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
